// File: rtl/trng_pkg.sv
// Shared definitions for the trng source and its downstream health monitor:
// sample width, default health-test limits and FSM state encodings.
package trng_pkg;

  // Sample width shared with the trng core
  localparam int DATA_W = 8;

  // Default health-test limits
  localparam int RCT_CUTOFF_DEF      = 8;
  localparam int APT_WINDOW_DEF      = 64;
  localparam int APT_CUTOFF_DEF      = 20;
  localparam int STARTUP_SAMPLES_DEF = 128;

  // Monitor FSM state encodings
  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_ALARM   = 2'd2;

endpackage

// File: rtl/trng_rct.sv
// Repetition-count test: tracks the last sample and the length of the current
// run of identical samples. fail is combinational for the sample presented this
// cycle so the caller can act on the same clock edge.
module trng_rct
  import trng_pkg::*;
#(
  parameter int W          = DATA_W,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         restart,
  input  logic         sample_en,
  input  logic [W-1:0] rand_in,
  output logic         fail
);

  localparam int CW = $clog2(RCT_CUTOFF + 1);

  logic [W-1:0]  last_reg;
  logic [CW-1:0] rct_cnt_reg;
  logic          ref_valid_reg;
  logic          repeat_hit;

  assign repeat_hit = ref_valid_reg && (rand_in == last_reg);
  // A repeat that would bring the run length to the cutoff is the failure
  assign fail = sample_en && repeat_hit && (rct_cnt_reg == CW'(RCT_CUTOFF - 1));

  // Run-length tracking; a failing sample leaves the state untouched so the
  // count never exceeds the cutoff while the monitor sits in alarm
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      last_reg      <= '0;
      rct_cnt_reg   <= '0;
      ref_valid_reg <= 1'b0;
    end else if (sample_en && !fail) begin
      if (repeat_hit) begin
        rct_cnt_reg <= rct_cnt_reg + CW'(1);
      end else begin
        last_reg      <= rand_in;
        rct_cnt_reg   <= CW'(1);
        ref_valid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/trng_health_monitor.sv
// Online health monitor and output gate for the raw trng byte stream.
// Runs a repetition-count test (trng_rct) and an adaptive-proportion test,
// forwards only healthy samples taken in RUN over a valid/ready interface,
// and latches a sticky alarm that only clear_alarm releases.
// Optional build macro TRNG_HEALTH_STATS_EN adds fail_count / drop_count ports.
module trng_health_monitor
  import trng_pkg::*;
#(
  parameter int W               = DATA_W,
  parameter int RCT_CUTOFF      = RCT_CUTOFF_DEF,
  parameter int APT_WINDOW      = APT_WINDOW_DEF,
  parameter int APT_CUTOFF      = APT_CUTOFF_DEF,
  parameter int STARTUP_SAMPLES = STARTUP_SAMPLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] rand_in,
  input  logic         clear_alarm,
  output logic [W-1:0] rand_out,
  output logic         rand_valid,
  input  logic         rand_ready,
  output logic         health_ok,
  output logic         alarm
`ifdef TRNG_HEALTH_STATS_EN
  ,
  output logic [15:0]  fail_count,
  output logic [15:0]  drop_count
`endif
);

  localparam int AW = $clog2(APT_CUTOFF + 1);
  localparam int IW = $clog2(APT_WINDOW + 1);
  localparam int SW = $clog2(STARTUP_SAMPLES + 1);

  logic [1:0]    state_reg;
  logic [SW-1:0] startup_cnt_reg;
  logic [W-1:0]  apt_ref_reg;
  logic [AW-1:0] apt_cnt_reg;
  logic [IW-1:0] win_idx_reg;
  logic [W-1:0]  out_reg;
  logic          valid_reg;

  logic active;
  logic restart;
  logic rct_fail;
  logic apt_first;
  logic apt_match;
  logic apt_fail;
  logic any_fail;
  logic pass;
  logic slot_free;

  // Tests run in STARTUP and RUN; ALARM freezes everything
  assign active  = (state_reg != ST_ALARM);
  assign restart = (state_reg == ST_ALARM) && clear_alarm;

  trng_rct #(
    .W          (W),
    .RCT_CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .sample_en (active),
    .rand_in   (rand_in),
    .fail      (rct_fail)
  );

  // win_idx == 0 marks the first sample of a window, which becomes the reference
  assign apt_first = (win_idx_reg == '0);
  assign apt_match = !apt_first && (rand_in == apt_ref_reg);
  assign apt_fail  = active && apt_match && (apt_cnt_reg == AW'(APT_CUTOFF - 1));
  assign any_fail  = rct_fail || apt_fail;
  assign pass      = active && !any_fail;
  assign slot_free = !valid_reg || rand_ready;

  // Adaptive-proportion window: reference, match count and position in window
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      apt_ref_reg <= '0;
      apt_cnt_reg <= '0;
      win_idx_reg <= '0;
    end else if (pass) begin
      if (apt_first) begin
        apt_ref_reg <= rand_in;
        apt_cnt_reg <= AW'(1);
        win_idx_reg <= IW'(1);
      end else begin
        win_idx_reg <= (win_idx_reg == IW'(APT_WINDOW - 1)) ? '0 : win_idx_reg + IW'(1);
        if (apt_match) begin
          apt_cnt_reg <= apt_cnt_reg + AW'(1);
        end
      end
    end
  end

  // Monitor FSM with the startup pass counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_STARTUP;
      startup_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_STARTUP: begin
          if (any_fail) begin
            state_reg <= ST_ALARM;
          end else if (startup_cnt_reg == SW'(STARTUP_SAMPLES - 1)) begin
            state_reg       <= ST_RUN;
            startup_cnt_reg <= '0;
          end else begin
            startup_cnt_reg <= startup_cnt_reg + SW'(1);
          end
        end
        ST_RUN: begin
          if (any_fail) begin
            state_reg <= ST_ALARM;
          end
        end
        ST_ALARM: begin
          if (clear_alarm) begin
            state_reg       <= ST_STARTUP;
            startup_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg       <= ST_STARTUP;
          startup_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Output register: load healthy RUN samples when the slot is free, discard
  // any pending byte on the edge that enters ALARM
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (active && any_fail) begin
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else if ((state_reg == ST_RUN) && pass && slot_free) begin
      out_reg   <= rand_in;
      valid_reg <= 1'b1;
    end else if (valid_reg && rand_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign rand_out   = out_reg;
  assign rand_valid = valid_reg;
  assign health_ok  = (state_reg == ST_RUN);
  assign alarm      = (state_reg == ST_ALARM);

`ifdef TRNG_HEALTH_STATS_EN
  logic [15:0] fail_count_reg;
  logic [15:0] drop_count_reg;

  // Saturating failure and backpressure-drop counters; only reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_count_reg <= '0;
      drop_count_reg <= '0;
    end else begin
      if (active && any_fail && (fail_count_reg != 16'hFFFF)) begin
        fail_count_reg <= fail_count_reg + 16'd1;
      end
      if ((state_reg == ST_RUN) && pass && !slot_free && (drop_count_reg != 16'hFFFF)) begin
        drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  assign fail_count = fail_count_reg;
  assign drop_count = drop_count_reg;
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_trng_health_monitor.sv
// Directed bench for trng_health_monitor. Bytes the bench expects to be
// forwarded are queued as they are driven and compared when the consumer
// handshake takes them. Build with TRNG_HEALTH_STATS_EN to cover the counters.
module tb_trng_health_monitor;

  logic       clk;
  logic       reset;
  logic [7:0] rand_in;
  logic       clear_alarm;
  logic [7:0] rand_out;
  logic       rand_valid;
  logic       rand_ready;
  logic       health_ok;
  logic       alarm;
`ifdef TRNG_HEALTH_STATS_EN
  logic [15:0] fail_count;
  logic [15:0] drop_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb[$];
  logic [7:0] rv;
  logic [7:0] held;
  logic [7:0] d;

  trng_health_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .rand_in     (rand_in),
    .clear_alarm (clear_alarm),
    .rand_out    (rand_out),
    .rand_valid  (rand_valid),
    .rand_ready  (rand_ready),
    .health_ok   (health_ok),
    .alarm       (alarm)
`ifdef TRNG_HEALTH_STATS_EN
    ,
    .fail_count  (fail_count),
    .drop_count  (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one sample, settle any handshake against the scoreboard, then step
  // past the edge so outputs are read 1 time unit after it
  task automatic tick(input logic [7:0] din, input logic rdy, input logic clr, input logic push);
    logic [7:0] exp_b;
    rand_in     = din;
    rand_ready  = rdy;
    clear_alarm = clr;
    if (rand_valid && rand_ready) begin
      chk("byte_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        chk("byte_value", rand_out, exp_b);
      end
    end
    if (push) sb.push_back(din);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    rand_in     = 8'h00;
    rand_ready  = 1'b1;
    clear_alarm = 1'b0;
    rv          = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", rand_out, 8'h00);
    chk("rst_valid", rand_valid, 1'b0);
    chk("rst_health", health_ok, 1'b0);
    chk("rst_alarm", alarm, 1'b0);
`ifdef TRNG_HEALTH_STATS_EN
    chk("rst_fail_cnt", fail_count, 16'd0);
    chk("rst_drop_cnt", drop_count, 16'd0);
`endif
    reset = 1'b0;

    // Startup: 128 ramp samples, nothing forwarded
    for (int i = 0; i < 128; i++) begin
      tick(rv, 1'b1, 1'b0, 1'b0);
      rv++;
      chk("startup_valid", rand_valid, 1'b0);
      if (i == 126) chk("startup_health_early", health_ok, 1'b0);
    end
    chk("run_health", health_ok, 1'b1);
    chk("run_alarm", alarm, 1'b0);

    // RUN ramp, full throughput
    for (int i = 0; i < 20; i++) begin
      tick(rv, 1'b1, 1'b0, 1'b1);
      chk("ramp_valid", rand_valid, 1'b1);
      chk("ramp_out", rand_out, rv);
      rv++;
    end

    // RCT: eight identical samples, the eighth fails and is not forwarded
    for (int k = 0; k < 8; k++) begin
      tick(8'hA5, 1'b1, 1'b0, (k < 7));
      if (k < 7) begin
        chk("rct_alarm_early", alarm, 1'b0);
      end else begin
        chk("rct_alarm", alarm, 1'b1);
        chk("rct_valid", rand_valid, 1'b0);
        chk("rct_out", rand_out, 8'h00);
        chk("rct_health", health_ok, 1'b0);
      end
    end
    chk("rct_pending", sb.size(), 0);

    // ALARM ignores all input
    for (int i = 0; i < 5; i++) begin
      tick(rv, 1'b1, 1'b0, 1'b0);
      rv++;
      chk("alarm_hold", alarm, 1'b1);
      chk("alarm_valid", rand_valid, 1'b0);
    end

    // APT with 20 matches to reference 0x3C
    tick(rv, 1'b1, 1'b1, 1'b0);
    rv++;
    chk("clear_alarm", alarm, 1'b0);
    chk("clear_health", health_ok, 1'b0);
    for (int p = 0; p < 39; p++) begin
      d = (p % 2 == 0) ? 8'h3C : 8'h80 + 8'(p);
      tick(d, 1'b1, 1'b0, 1'b0);
      if (p < 38) chk("apt20_alarm_early", alarm, 1'b0);
      else        chk("apt20_alarm", alarm, 1'b1);
    end

    // APT with 19 matches: passes, then startup completes into RUN
    tick(rv, 1'b1, 1'b1, 1'b0);
    rv++;
    chk("clear2_alarm", alarm, 1'b0);
    for (int p = 0; p < 64; p++) begin
      d = ((p % 2 == 0) && (p <= 36)) ? 8'h3C : 8'h80 + 8'(p);
      tick(d, 1'b1, 1'b0, 1'b0);
      chk("apt19_alarm", alarm, 1'b0);
    end
    for (int p = 0; p < 64; p++) begin
      tick(rv, 1'b1, 1'b0, 1'b0);
      rv++;
      if (p == 62) chk("restart_health_early", health_ok, 1'b0);
    end
    chk("restart_health", health_ok, 1'b1);

    // Backpressure: held byte stays put while samples are dropped
    for (int i = 0; i < 5; i++) begin
      tick(rv, 1'b1, 1'b0, 1'b1);
      held = rv;
      rv++;
    end
    for (int i = 0; i < 10; i++) begin
      tick(rv, 1'b0, 1'b0, 1'b0);
      rv++;
      chk("bp_valid", rand_valid, 1'b1);
      chk("bp_hold", rand_out, held);
    end
`ifdef TRNG_HEALTH_STATS_EN
    chk("bp_drop_cnt", drop_count, 16'd10);
`endif
    tick(rv, 1'b1, 1'b0, 1'b1);
    chk("bp_resume_out", rand_out, rv);
    chk("bp_resume_valid", rand_valid, 1'b1);
    rv++;
    for (int i = 0; i < 3; i++) begin
      tick(rv, 1'b1, 1'b0, 1'b1);
      rv++;
    end

    // clear_alarm in RUN has no effect
    tick(rv, 1'b1, 1'b1, 1'b1);
    rv++;
    chk("clr_run_health", health_ok, 1'b1);
    chk("clr_run_alarm", alarm, 1'b0);
    chk("clr_run_valid", rand_valid, 1'b1);
    tick(rv, 1'b1, 1'b0, 1'b1);
    rv++;
`ifdef TRNG_HEALTH_STATS_EN
    chk("fail_cnt", fail_count, 16'd2);
`endif

    // Reset mid-RUN discards the pending byte
    reset = 1'b1;
    tick(rv, 1'b0, 1'b0, 1'b0);
    rv++;
    chk("mid_rst_out", rand_out, 8'h00);
    chk("mid_rst_valid", rand_valid, 1'b0);
    chk("mid_rst_health", health_ok, 1'b0);
    chk("mid_rst_alarm", alarm, 1'b0);
`ifdef TRNG_HEALTH_STATS_EN
    chk("mid_rst_fail_cnt", fail_count, 16'd0);
    chk("mid_rst_drop_cnt", drop_count, 16'd0);
`endif
    chk("mid_rst_pending", sb.size(), 1);
    sb.delete();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(rv, 1'b1, 1'b0, 1'b0);
      rv++;
      chk("post_rst_valid", rand_valid, 1'b0);
      chk("post_rst_health", health_ok, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
